// File: rtl/tick_to_level.sv
// Regenerates single-cycle tick requests as fixed-width level pulses with a
// guaranteed low gap, queuing ticks that arrive while a pulse is in progress.
module tick_to_level #(
  parameter int unsigned HIGH_CYCLES = 4,
  parameter int unsigned LOW_CYCLES  = 2,
  parameter int unsigned PEND_MAX    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       clr_ovf,
  output logic       level,
  output logic       busy,
  output logic [3:0] pending,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] HI_LOAD = 8'(HIGH_CYCLES - 1);
  localparam logic [7:0] LO_LOAD = 8'(LOW_CYCLES - 1);
  localparam logic [3:0] PMAX    = 4'(PEND_MAX);

  state_t     state;
  logic [7:0] timer;

  logic timer_zero;
  logic gap_exit;
  logic restart;
  logic queue_tick;
  logic drop;
  logic illegal;

  always_comb begin
    timer_zero = (timer == '0);
    gap_exit   = (state == GAP) && timer_zero;
    restart    = gap_exit && ((pending != '0) || tick);
    // A tick on the GAP exit edge is never queued: it is either consumed
    // directly or cancels out against the dequeue of the next pulse.
    queue_tick = tick && ((state == HIGH) || ((state == GAP) && !gap_exit));
    drop       = queue_tick && (pending >= PMAX);
    case (state)
      IDLE:    illegal = !timer_zero || (pending != '0);
      HIGH:    illegal = (timer > HI_LOAD) || (pending > PMAX);
      GAP:     illegal = (timer > LO_LOAD) || (pending > PMAX);
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      level    <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else if (illegal) begin
      state    <= IDLE;
      timer    <= '0;
      level    <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= overflow && !clr_ovf;
    end else begin
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;

      if (queue_tick && !drop)
        pending <= pending + 4'd1;
      else if (restart && !tick)
        pending <= pending - 4'd1;

      case (state)
        IDLE: begin
          if (tick) begin
            state <= HIGH;
            timer <= HI_LOAD;
            level <= 1'b1;
            busy  <= 1'b1;
          end
        end
        HIGH: begin
          if (timer_zero) begin
            state <= GAP;
            timer <= LO_LOAD;
            level <= 1'b0;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        GAP: begin
          if (restart) begin
            state <= HIGH;
            timer <= HI_LOAD;
            level <= 1'b1;
          end else if (gap_exit) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          level <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_to_level.sv
// Self-checking bench for tick_to_level: directed scenarios plus random
// stimulus, compared against a pulse-schedule reference model.
module tb_tick_to_level;

  localparam int H = 4;
  localparam int L = 2;
  localparam int P = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       level;
  logic       busy;
  logic [3:0] pending;
  logic       overflow;

  tick_to_level #(
    .HIGH_CYCLES(H),
    .LOW_CYCLES (L),
    .PEND_MAX   (P)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .clr_ovf (clr_ovf),
    .level   (level),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: each accepted tick becomes a scheduled pulse start cycle.
  int starts[$];
  int last_s = -1000;
  bit m_ovf = 1'b0;
  int cyc = -1;

  bit prev_lvl = 1'b0;
  int rises = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit t, input bit c, input bit r);
    int s;
    int cnt;
    bit dropped;
    cyc++;
    if (r) begin
      starts.delete();
      last_s = -1000;
      m_ovf  = 1'b0;
    end else begin
      dropped = 1'b0;
      if (t) begin
        s   = (last_s + H + L > cyc) ? last_s + H + L : cyc;
        cnt = (s > cyc) ? 1 : 0;
        foreach (starts[i]) if (starts[i] > cyc) cnt++;
        if (cnt > P) dropped = 1'b1;
        else begin
          starts.push_back(s);
          last_s = s;
        end
      end
      if (dropped) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
    end
    while (starts.size() > 0 && starts[0] + H + L <= cyc) void'(starts.pop_front());
  endtask

  task automatic compare();
    int exp_lvl = 0;
    int exp_busy = 0;
    int exp_pend = 0;
    foreach (starts[i]) begin
      if (starts[i] <= cyc && cyc <= starts[i] + H - 1) exp_lvl = 1;
      if (starts[i] <= cyc && cyc <= starts[i] + H + L - 1) exp_busy = 1;
      if (starts[i] > cyc) exp_pend++;
    end
    chk("level", int'(level), exp_lvl);
    chk("busy", int'(busy), exp_busy);
    chk("pending", int'(pending), exp_pend);
    chk("overflow", int'(overflow), int'(m_ovf));
    if (level && !prev_lvl) rises++;
    prev_lvl = level;
  endtask

  task automatic step(input bit t, input bit c, input bit r);
    tick    = t;
    clr_ovf = c;
    reset   = r;
    @(posedge clk);
    model_edge(t, c, r);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset, with tick and clr_ovf asserted to confirm reset priority.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);

    // Single tick on the first edge out of reset.
    step(1'b1, 1'b0, 1'b0);
    idle(8);

    // Two back-to-back ticks.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(14);

    // Five ticks: saturation, drop, sticky overflow, then clear.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    idle(30);
    chk("ovf_sticky", int'(overflow), 1);
    step(1'b0, 1'b1, 1'b0);
    chk("ovf_cleared", int'(overflow), 0);

    // Tick on the final GAP edge with nothing pending.
    step(1'b1, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 1'b0, 1'b0);
    idle(12);

    // Reset mid-pulse with two ticks queued, then a fresh tick.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 1'b0);
    idle(8);

    // clr_ovf coinciding with a drop: the drop wins.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("ovf_set_wins", int'(overflow), 1);
    step(1'b0, 1'b1, 1'b0);
    idle(30);

    // Random stimulus.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 99) == 0);

    // Loopback: widely spaced ticks must each come back as one pulse.
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0);
      idle(5 + $urandom_range(0, 4));
    end
    idle(10);
    chk("loopback_rises", rises, 20);
    chk("loopback_ovf", int'(overflow), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
